// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage access controller with handshaked data port
// Alignment check, lane steering, ack wait with timeout, and load extension.
module mem_access_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] ReadData2In,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  MemSizeIn,
  input  logic        MemUnsignedIn,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBe,
  output logic [31:0] LoadData,
  output logic        Stall,
  output logic        MisalignErr,
  output logic        BusErr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} stateT;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LastCount = CW'(TIMEOUT - 1);

  stateT          state;
  logic [CW-1:0]  waitCount;
  logic [1:0]     addrLo;
  logic [1:0]     sizeReg;
  logic           unsignedReg;

  logic           access;
  logic           misaligned;
  logic [3:0]     beNext;
  logic [31:0]    wDataNext;
  logic [31:0]    shifted;
  logic [31:0]    loadNext;

  always_comb begin
    access     = MemReadIn | MemWriteIn;
    misaligned = 1'b0;
    beNext     = 4'b1111;
    wDataNext  = ReadData2In;
    case (MemSizeIn)
      2'b00: begin
        beNext    = 4'b0001 << ALUResultIn[1:0];
        wDataNext = {4{ReadData2In[7:0]}};
      end
      2'b01: begin
        misaligned = ALUResultIn[0];
        beNext     = 4'b0011 << {ALUResultIn[1], 1'b0};
        wDataNext  = {2{ReadData2In[15:0]}};
      end
      default: misaligned = |ALUResultIn[1:0];
    endcase
  end

  // Little-endian lane select from the captured byte offset, then extend.
  always_comb begin
    shifted  = MemRData;
    loadNext = MemRData;
    case (sizeReg)
      2'b00: begin
        shifted  = MemRData >> {addrLo, 3'b000};
        loadNext = {{24{~unsignedReg & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        shifted  = MemRData >> {addrLo[1], 4'b0000};
        loadNext = {{16{~unsignedReg & shifted[15]}}, shifted[15:0]};
      end
      default: loadNext = MemRData;
    endcase
  end

  assign Stall = ((state == IDLE) & access & ~misaligned) | (state == REQ);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      waitCount   <= '0;
      addrLo      <= 2'b00;
      sizeReg     <= 2'b00;
      unsignedReg <= 1'b0;
      MemReq      <= 1'b0;
      MemWe       <= 1'b0;
      MemAddr     <= '0;
      MemWData    <= '0;
      MemBe       <= '0;
      LoadData    <= '0;
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
    end else begin
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
      case (state)
        IDLE: begin
          if (access && misaligned) begin
            MisalignErr <= 1'b1;
          end else if (access) begin
            MemReq      <= 1'b1;
            MemWe       <= MemWriteIn;
            MemAddr     <= {ALUResultIn[31:2], 2'b00};
            MemWData    <= wDataNext;
            MemBe       <= beNext;
            addrLo      <= ALUResultIn[1:0];
            sizeReg     <= MemSizeIn;
            unsignedReg <= MemUnsignedIn;
            waitCount   <= '0;
            state       <= REQ;
          end
        end
        REQ: begin
          // An ack landing on the final allowed cycle still wins over the timeout.
          if (MemAck) begin
            MemReq <= 1'b0;
            if (!MemWe) LoadData <= loadNext;
            state  <= DONE;
          end else if (waitCount == LastCount) begin
            MemReq   <= 1'b0;
            LoadData <= '0;
            BusErr   <= 1'b1;
            state    <= DONE;
          end else begin
            waitCount <= waitCount + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
